// File: rtl/csr_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : csr_arb_pkg
// Description : Shared types and constants for the CSR write-port arbiter.
//               Provides the grant-source encoding, the buffered-write
//               record and the default write-buffer depth.
// Revision    : 1.0 - initial release
// ============================================================================
package csr_arb_pkg;

  localparam int CSR_ARB_DEPTH_DEF = 2;
  localparam int CSR_ADDR_W        = 32;
  localparam int CSR_DATA_W        = 32;

  typedef enum logic [1:0] {
    GNT_NONE = 2'd0,
    GNT_TRAP = 2'd1,
    GNT_FIFO = 2'd2,
    GNT_EX   = 2'd3
  } grant_src_e;

  typedef struct packed {
    logic [CSR_ADDR_W-1:0] addr;
    logic [CSR_DATA_W-1:0] data;
  } csr_wr_t;

endpackage
`default_nettype wire

// File: rtl/csr_wbuf_fifo.sv
`default_nettype none
// ============================================================================
// Module      : csr_wbuf_fifo
// Description : DEPTH-entry FIFO of pending EX CSR writes. Entries are
//               presented in age order (index 0 = head/oldest) together with
//               a valid vector so the parent can run a forwarding search.
// Ports       : clk, rst      - clock, synchronous active-high reset
//               i_push/i_wr   - enqueue a write record
//               i_pop         - dequeue the head
//               i_flush       - discard all entries
//               o_entries     - entries ordered oldest..youngest
//               o_valid       - per-position valid (age order)
//               o_full/o_empty/o_count - occupancy status
// Revision    : 1.0 - initial release
// ============================================================================
module csr_wbuf_fifo
  import csr_arb_pkg::*;
#(
  parameter int DEPTH = CSR_ARB_DEPTH_DEF,
  parameter int PTR_W = $clog2(DEPTH),
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_push,
  input  csr_wr_t               i_wr,
  input  logic                  i_pop,
  input  logic                  i_flush,
  output csr_wr_t [DEPTH-1:0]   o_entries,
  output logic    [DEPTH-1:0]   o_valid,
  output logic                  o_full,
  output logic                  o_empty,
  output logic    [CNT_W-1:0]   o_count
);

  csr_wr_t [DEPTH-1:0] r_mem;
  logic    [PTR_W-1:0] r_wr_ptr;
  logic    [PTR_W-1:0] r_rd_ptr;
  logic    [CNT_W-1:0] r_count;

  // Storage carries no reset; validity is tracked by the count alone.
  always_ff @(posedge clk) begin
    if (i_push && !i_flush && !rst) begin
      r_mem[r_wr_ptr] <= i_wr;
    end
  end

  // DEPTH is a power of two, so pointers wrap naturally.
  always_ff @(posedge clk) begin
    if (rst || i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (i_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (i_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({i_push, i_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Rotate physical slots into age order for the forwarding search.
  for (genvar g = 0; g < DEPTH; g++) begin : g_age_view
    assign o_entries[g] = r_mem[r_rd_ptr + PTR_W'(g)];
    assign o_valid[g]   = (CNT_W'(g) < r_count);
  end

  assign o_full  = (r_count == CNT_W'(DEPTH));
  assign o_empty = (r_count == '0);
  assign o_count = r_count;

endmodule
`default_nettype wire

// File: rtl/csr_wport_arb.sv
`default_nettype none
// ============================================================================
// Module      : csr_wport_arb
// Description : Arbiter and write buffer for the single CSR-file write port.
//               Trap-sequencer writes are never stalled; EX CSR writes bypass
//               when the port is free and are otherwise buffered and drained
//               in order. Pending writes are forwarded to EX reads.
// Ports       : clk, rst                      - clock, sync active-high reset
//               trap_we_i/waddr_i/wdata_i      - trap write (always accepted)
//               trap_busy_i                    - blocks buffer drain
//               ex_valid_i/ex_ready_o/...      - EX write handshake
//               flush_i                        - drop buffered + same-cycle EX
//               fwd_raddr_i/fwd_hit_o/fwd_data_o - forwarding lookup
//               csr_we_o/csr_waddr_o/csr_wdata_o - registered CSR write port
//               drained_o                      - nothing pending anywhere
// Revision    : 1.0 - initial release
// ============================================================================
module csr_wport_arb
  import csr_arb_pkg::*;
#(
  parameter int ADDR_W = CSR_ADDR_W,
  parameter int DATA_W = CSR_DATA_W,
  parameter int DEPTH  = CSR_ARB_DEPTH_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              trap_we_i,
  input  logic [ADDR_W-1:0] trap_waddr_i,
  input  logic [DATA_W-1:0] trap_wdata_i,
  input  logic              trap_busy_i,
  input  logic              ex_valid_i,
  output logic              ex_ready_o,
  input  logic [ADDR_W-1:0] ex_waddr_i,
  input  logic [DATA_W-1:0] ex_wdata_i,
  input  logic              flush_i,
  input  logic [ADDR_W-1:0] fwd_raddr_i,
  output logic              fwd_hit_o,
  output logic [DATA_W-1:0] fwd_data_o,
  output logic              csr_we_o,
  output logic [ADDR_W-1:0] csr_waddr_o,
  output logic [DATA_W-1:0] csr_wdata_o,
  output logic              drained_o
);

  localparam int CNT_W = $clog2(DEPTH + 1);

  grant_src_e          w_grant;
  logic                w_push;
  logic                w_pop;
  logic                w_ex_acc;
  logic                w_full;
  logic                w_empty;
  logic [CNT_W-1:0]    w_count;
  csr_wr_t             w_ex_wr;
  csr_wr_t [DEPTH-1:0] w_entries;
  logic    [DEPTH-1:0] w_valid;
  logic [ADDR_W-1:0]   w_sel_addr;
  logic [DATA_W-1:0]   w_sel_data;

  logic                r_we;
  logic [ADDR_W-1:0]   r_waddr;
  logic [DATA_W-1:0]   r_wdata;

  // Ready is a function of occupancy only, so a same-cycle pop on a full
  // buffer does not open the door until the next cycle.
  assign ex_ready_o = !w_full && !rst;
  assign w_ex_acc   = ex_valid_i && ex_ready_o;

  assign w_ex_wr.addr = CSR_ADDR_W'(ex_waddr_i);
  assign w_ex_wr.data = CSR_DATA_W'(ex_wdata_i);

  always_comb begin
    w_grant = GNT_NONE;
    w_pop   = 1'b0;
    if (trap_we_i) begin
      w_grant = GNT_TRAP;
    end else if (!trap_busy_i && !w_empty && !flush_i) begin
      w_grant = GNT_FIFO;
      w_pop   = 1'b1;
    end else if (!trap_busy_i && w_empty && w_ex_acc && !flush_i) begin
      w_grant = GNT_EX;
    end
    w_push = w_ex_acc && !flush_i && (w_grant != GNT_EX);
  end

  csr_wbuf_fifo #(
    .DEPTH     (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .i_push    (w_push),
    .i_wr      (w_ex_wr),
    .i_pop     (w_pop),
    .i_flush   (flush_i),
    .o_entries (w_entries),
    .o_valid   (w_valid),
    .o_full    (w_full),
    .o_empty   (w_empty),
    .o_count   (w_count)
  );

  always_comb begin
    w_sel_addr = r_waddr;
    w_sel_data = r_wdata;
    case (w_grant)
      GNT_TRAP: begin
        w_sel_addr = trap_waddr_i;
        w_sel_data = trap_wdata_i;
      end
      GNT_FIFO: begin
        w_sel_addr = ADDR_W'(w_entries[0].addr);
        w_sel_data = DATA_W'(w_entries[0].data);
      end
      GNT_EX: begin
        w_sel_addr = ex_waddr_i;
        w_sel_data = ex_wdata_i;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_we    <= 1'b0;
      r_waddr <= '0;
      r_wdata <= '0;
    end else begin
      r_we <= (w_grant != GNT_NONE);
      if (w_grant != GNT_NONE) begin
        r_waddr <= w_sel_addr;
        r_wdata <= w_sel_data;
      end
    end
  end

  assign csr_we_o    = r_we;
  assign csr_waddr_o = r_waddr;
  assign csr_wdata_o = r_wdata;
  assign drained_o   = (w_count == '0) && !r_we;

  // Lowest priority is evaluated first so that later (younger) matches
  // overwrite it: output stage, then FIFO oldest to youngest.
  always_comb begin
    fwd_hit_o  = 1'b0;
    fwd_data_o = '0;
    if (r_we && (r_waddr == fwd_raddr_i)) begin
      fwd_hit_o  = 1'b1;
      fwd_data_o = r_wdata;
    end
    for (int k = 0; k < DEPTH; k++) begin
      if (w_valid[k] && (w_entries[k].addr == CSR_ADDR_W'(fwd_raddr_i))) begin
        fwd_hit_o  = 1'b1;
        fwd_data_o = DATA_W'(w_entries[k].data);
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_csr_wport_arb.sv
`default_nettype none
// ============================================================================
// Module      : tb_csr_wport_arb
// Description : Self-checking bench for csr_wport_arb. Expected CSR writes are
//               queued when stimulus is applied and matched, in order, against
//               every cycle the DUT asserts csr_we_o.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_csr_wport_arb;

  logic        clk;
  logic        rst;
  logic        trap_we_i;
  logic [31:0] trap_waddr_i;
  logic [31:0] trap_wdata_i;
  logic        trap_busy_i;
  logic        ex_valid_i;
  logic        ex_ready_o;
  logic [31:0] ex_waddr_i;
  logic [31:0] ex_wdata_i;
  logic        flush_i;
  logic [31:0] fwd_raddr_i;
  logic        fwd_hit_o;
  logic [31:0] fwd_data_o;
  logic        csr_we_o;
  logic [31:0] csr_waddr_o;
  logic [31:0] csr_wdata_o;
  logic        drained_o;

  typedef struct {
    logic [31:0] a;
    logic [31:0] d;
  } wr_t;

  wr_t sb[$];
  int  n_chk = 0;
  int  n_err = 0;

  csr_wport_arb #(
    .ADDR_W       (32),
    .DATA_W       (32),
    .DEPTH        (2)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .trap_we_i    (trap_we_i),
    .trap_waddr_i (trap_waddr_i),
    .trap_wdata_i (trap_wdata_i),
    .trap_busy_i  (trap_busy_i),
    .ex_valid_i   (ex_valid_i),
    .ex_ready_o   (ex_ready_o),
    .ex_waddr_i   (ex_waddr_i),
    .ex_wdata_i   (ex_wdata_i),
    .flush_i      (flush_i),
    .fwd_raddr_i  (fwd_raddr_i),
    .fwd_hit_o    (fwd_hit_o),
    .fwd_data_o   (fwd_data_o),
    .csr_we_o     (csr_we_o),
    .csr_waddr_o  (csr_waddr_o),
    .csr_wdata_o  (csr_wdata_o),
    .drained_o    (drained_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  task automatic exp_wr(input logic [31:0] a, input logic [31:0] d);
    wr_t e;
    e.a = a;
    e.d = d;
    sb.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ex_drive(input logic [31:0] a, input logic [31:0] d);
    ex_valid_i = 1'b1;
    ex_waddr_i = a;
    ex_wdata_i = d;
  endtask

  // Every CSR write must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (!rst && csr_we_o) begin
      if (sb.size() == 0) begin
        chk("unexp_wr", 32'(csr_we_o), 32'd0);
      end else begin
        wr_t e;
        e = sb.pop_front();
        chk("wr_addr", csr_waddr_o, e.a);
        chk("wr_data", csr_wdata_o, e.d);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] d;
    rst          = 1'b1;
    trap_we_i    = 1'b0;
    trap_waddr_i = '0;
    trap_wdata_i = '0;
    trap_busy_i  = 1'b0;
    ex_valid_i   = 1'b0;
    ex_waddr_i   = '0;
    ex_wdata_i   = '0;
    flush_i      = 1'b0;
    fwd_raddr_i  = '0;

    // Reset and idle
    repeat (3) tick();
    chk("rst_we", 32'(csr_we_o), 32'd0);
    chk("rst_ready", 32'(ex_ready_o), 32'd0);
    chk("rst_drained", 32'(drained_o), 32'd1);
    chk("rst_waddr", csr_waddr_o, 32'd0);
    rst = 1'b0;
    #1;
    chk("idle_ready", 32'(ex_ready_o), 32'd1);
    tick();

    // Bypass
    ex_drive(32'h300, 32'h88);
    exp_wr(32'h300, 32'h88);
    tick();
    ex_valid_i  = 1'b0;
    fwd_raddr_i = 32'h300;
    #1;
    chk("byp_fwd_hit", 32'(fwd_hit_o), 32'd1);
    chk("byp_fwd_data", fwd_data_o, 32'h88);
    chk("byp_drained", 32'(drained_o), 32'd0);
    tick();
    chk("byp_drained2", 32'(drained_o), 32'd1);
    chk("nomatch_hit", 32'(fwd_hit_o), 32'd0);
    chk("nomatch_data", fwd_data_o, 32'd0);

    // Collision: trap wins, EX is buffered then drained
    trap_we_i    = 1'b1;
    trap_waddr_i = 32'h341;
    trap_wdata_i = 32'h8000_0100;
    ex_drive(32'h305, 32'h1000);
    exp_wr(32'h341, 32'h8000_0100);
    exp_wr(32'h305, 32'h1000);
    tick();
    trap_we_i   = 1'b0;
    ex_valid_i  = 1'b0;
    fwd_raddr_i = 32'h305;
    #1;
    chk("col_fwd_hit", 32'(fwd_hit_o), 32'd1);
    chk("col_fwd_data", fwd_data_o, 32'h1000);
    tick();
    tick();
    chk("col_drained", 32'(drained_o), 32'd1);

    // Busy hold and full
    trap_busy_i = 1'b1;
    ex_drive(32'h340, 32'd1);
    #1;
    chk("busy_ready0", 32'(ex_ready_o), 32'd1);
    exp_wr(32'h340, 32'd1);
    tick();
    ex_drive(32'h340, 32'd2);
    #1;
    chk("busy_ready1", 32'(ex_ready_o), 32'd1);
    exp_wr(32'h340, 32'd2);
    tick();
    ex_drive(32'h305, 32'd3);
    fwd_raddr_i = 32'h340;
    #1;
    chk("full_ready", 32'(ex_ready_o), 32'd0);
    chk("full_fwd_hit", 32'(fwd_hit_o), 32'd1);
    chk("full_fwd_data", fwd_data_o, 32'd2);
    tick();
    ex_valid_i = 1'b0;
    chk("busy_drained", 32'(drained_o), 32'd0);
    tick();
    trap_busy_i = 1'b0;
    tick();
    tick();
    chk("drain_last_drained", 32'(drained_o), 32'd0);
    tick();
    chk("drain_done", 32'(drained_o), 32'd1);

    // Flush with a write in flight on the output stage
    trap_busy_i = 1'b1;
    ex_drive(32'h301, 32'hA);
    tick();
    ex_drive(32'h302, 32'hB);
    trap_we_i    = 1'b1;
    trap_waddr_i = 32'h342;
    trap_wdata_i = 32'h77;
    exp_wr(32'h342, 32'h77);
    tick();
    trap_we_i   = 1'b0;
    flush_i     = 1'b1;
    ex_drive(32'h303, 32'hC);
    fwd_raddr_i = 32'h302;
    #1;
    chk("fl_pre_hit", 32'(fwd_hit_o), 32'd1);
    chk("fl_pre_data", fwd_data_o, 32'hB);
    chk("fl_inflight_we", 32'(csr_we_o), 32'd1);
    tick();
    flush_i     = 1'b0;
    ex_valid_i  = 1'b0;
    trap_busy_i = 1'b0;
    #1;
    chk("fl_drained", 32'(drained_o), 32'd1);
    chk("fl_ready", 32'(ex_ready_o), 32'd1);
    chk("fl_post_hit", 32'(fwd_hit_o), 32'd0);
    repeat (3) tick();
    chk("fl_quiet", 32'(drained_o), 32'd1);

    // Wrap: keep one entry resident while pushing and popping each cycle
    trap_busy_i = 1'b1;
    d = $urandom;
    ex_drive(32'h340, d);
    exp_wr(32'h340, d);
    tick();
    trap_busy_i = 1'b0;
    for (int i = 0; i < 10; i++) begin
      d = $urandom;
      ex_drive(32'h340 + 32'(i & 3), d);
      exp_wr(32'h340 + 32'(i & 3), d);
      #1;
      chk("wrap_ready", 32'(ex_ready_o), 32'd1);
      tick();
    end
    ex_valid_i = 1'b0;
    repeat (3) tick();
    chk("wrap_drained", 32'(drained_o), 32'd1);
    chk("sb_empty", 32'(sb.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
